// File: rtl/mrsc_decoder_pkg.sv
// Shared MRSC types, codeword field offsets and index helpers.
package mrsc_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } status_e;

  localparam int unsigned OFF_DI = 16;
  localparam int unsigned OFF_P  = 20;
  localparam int unsigned OFF_CB = 24;

  typedef struct packed {
    logic [3:0]      sp;
    logic [3:0]      sd;
    logic [3:0][1:0] sc;
  } syn_t;

  // Diagonal that data bit (row b, column i) belongs to.
  function automatic logic [1:0] diag_idx(input int unsigned b, input int unsigned i);
    return 2'((i & 2) | ((i ^ b) & 1));
  endfunction

  // Di and P fields are stored in the order 0,3,1,2: slot of check bit n.
  function automatic int unsigned fld_slot(input int unsigned n);
    case (n)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/mrsc_decoder_if.sv
// Read-path handshake bundle: codeword in, corrected word and status out.
interface mrsc_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] out_data;
  logic [1:0]  out_status;

  modport slave  (input  in_valid, in_code, out_ready,
                  output in_ready, out_valid, out_data, out_status);
  modport master (output in_valid, in_code, out_ready,
                  input  in_ready, out_valid, out_data, out_status);
endinterface

// File: rtl/mrsc_decoder_syndrome.sv
// Combinational MRSC syndrome generator: received codeword to 16 syndrome bits.
module mrsc_syndrome
  import mrsc_pkg::*;
(
  input  logic [0:31] code_i,
  output syn_t        syn_o
);

  logic [3:0]      p_c;
  logic [3:0]      d_c;
  logic [3:0][1:0] c_c;

  // Recompute check bits from the data field and compare with the received ones.
  always_comb begin
    p_c   = '0;
    d_c   = '0;
    c_c   = '0;
    syn_o = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        p_c[i]              ^= code_i[4*i+b];
        d_c[diag_idx(b, i)] ^= code_i[4*i+b];
      end
      for (int unsigned k = 0; k < 2; k++) begin
        c_c[b][k] = code_i[4*k+b] ^ code_i[4*(k+2)+b];
      end
    end
    for (int unsigned n = 0; n < 4; n++) begin
      syn_o.sp[n] = code_i[OFF_P  + fld_slot(n)] ^ p_c[n];
      syn_o.sd[n] = code_i[OFF_DI + fld_slot(n)] ^ d_c[n];
      for (int unsigned k = 0; k < 2; k++) begin
        syn_o.sc[n][k] = code_i[OFF_CB + 2*n + k] ^ c_c[n][k];
      end
    end
  end

endmodule

// File: rtl/mrsc_decoder.sv
// Two-stage MRSC read-path decoder with single-data-bit correction and
// saturating corrected/uncorrectable counters.
module mrsc_decoder
  import mrsc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mrsc_decoder_if.slave        bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_uncorr
);

  syn_t        syn_d;
  syn_t        s1_syn_q;
  logic [0:15] s1_raw_q;   // data field of the codeword, still in codeword order
  logic        s1_valid_q;
  logic        out_valid_q;
  logic [0:15] out_data_q;
  logic [1:0]  out_status_q;
  logic [CNT_W-1:0] cnt_corr_q;
  logic [CNT_W-1:0] cnt_uncorr_q;

  logic        en1;
  logic        en2;
  logic        hs_out;
  logic [0:15] flip_v;
  logic [0:15] data_d;
  status_e     status_d;

  mrsc_syndrome u_syn (
    .code_i (bus.in_code),
    .syn_o  (syn_d)
  );

  assign en2    = !out_valid_q | bus.out_ready;
  assign en1    = !s1_valid_q | en2;
  assign hs_out = out_valid_q & bus.out_ready;

  assign bus.in_ready   = en1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_status = out_status_q;
  assign cnt_corr       = cnt_corr_q;
  assign cnt_uncorr     = cnt_uncorr_q;

  // Stage 1: capture the data field and its syndrome on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_syn_q   <= '0;
    end else if (en1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_raw_q <= bus.in_code[0:15];
        s1_syn_q <= syn_d;
      end
    end
  end

  // Correct the flagged data bit, reorder to data order and classify.
  always_comb begin
    flip_v = '0;
    data_d = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        flip_v[4*b+i] = s1_syn_q.sp[i] & s1_syn_q.sd[diag_idx(b, i)] & s1_syn_q.sc[b][i & 1];
        data_d[4*b+i] = s1_raw_q[4*i+b] ^ flip_v[4*b+i];
      end
    end
    if (s1_syn_q == '0)
      status_d = ST_CLEAN;
    else if ((|flip_v) || ($countones(s1_syn_q) == 1))
      status_d = ST_CORR;
    else
      status_d = ST_UNCORR;
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_CLEAN;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= data_d;
        out_status_q <= status_d;
      end
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (cnt_clr) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (hs_out) begin
      if (out_status_q == ST_CORR && cnt_corr_q != '1)
        cnt_corr_q <= cnt_corr_q + 1'b1;
      if (out_status_q == ST_UNCORR && cnt_uncorr_q != '1)
        cnt_uncorr_q <= cnt_uncorr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mrsc_decoder.sv
// Directed self-checking bench for mrsc_decoder (CNT_W=16 and CNT_W=4 copies).
module tb_mrsc_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic cnt_clr;
  logic [15:0] cnt_corr, cnt_uncorr;
  logic [3:0]  cnt_corr4, cnt_uncorr4;
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mrsc_decoder_if bus ();
  mrsc_decoder_if bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_code   = bus.in_code;
  assign bus4.out_ready = bus.out_ready;

  mrsc_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr));

  mrsc_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr4), .cnt_uncorr(cnt_uncorr4));

  localparam int DG [4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{0, 1, 2, 3}, '{1, 0, 3, 2}};
  localparam int SLOT [4]  = '{0, 2, 3, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:31] encode(input logic [0:15] d);
    logic [0:31] c;
    c = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        c[4*i+b]              = d[4*b+i];
        c[20 + SLOT[i]]       ^= d[4*b+i];
        c[16 + SLOT[DG[b][i]]] ^= d[4*b+i];
      end
      for (int k = 0; k < 2; k++) c[24+2*b+k] = d[4*b+k] ^ d[4*b+k+2];
    end
    return c;
  endfunction

  // One isolated word with out_ready high; optional counter clear on its output handshake.
  task automatic xfer(input logic [0:31] code, input logic [0:15] ed, input logic [1:0] es,
                      input bit clr, input string tag);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    check({tag, ".lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".data"}, 32'(bus.out_data), 32'(ed));
    check({tag, ".status"}, 32'(bus.out_status), 32'(es));
    cnt_clr = clr;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  logic [0:31] code;
  logic [0:15] dw;
  logic [0:15] sdata [8];
  logic [0:31] scode [8];
  logic [0:15] sexp  [8];
  logic [1:0]  sst   [8];
  bit          ordy  [16];

  initial begin
    int tx, rx;
    bit held, saw_full;
    logic [0:15] hd;
    logic [1:0]  hs;

    rst_n = 1'b1; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_code = '0; bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_data", 32'(bus.out_data), 32'd0);
    check("rst.out_status", 32'(bus.out_status), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.cnt_corr", 32'(cnt_corr), 32'd0);
    check("rst.cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    rst_n = 1'b1;

    xfer(32'hFFFF_0000, 16'hFFFF, 2'b00, 1'b0, "clean_ffff");
    check("clean.cnt_corr", 32'(cnt_corr), 32'd0);

    code = 32'hFFFF_0000; code[5] = ~code[5];
    xfer(code, 16'hFFFF, 2'b01, 1'b0, "err_bit5");
    check("bit5.cnt_corr", 32'(cnt_corr), 32'd1);

    xfer(encode(16'hA5C3), 16'hA5C3, 2'b00, 1'b0, "clean_a5c3");

    for (int w = 0; w < 2; w++) begin
      dw = (w == 0) ? 16'h0000 : 16'hA5C3;
      for (int j = 0; j < 16; j++) begin
        code = encode(dw);
        code[4*(j%4) + j/4] = ~code[4*(j%4) + j/4];
        xfer(code, dw, 2'b01, 1'b0, $sformatf("single_w%0d_d%0d", w, j));
      end
    end
    check("sweep.cnt_corr", 32'(cnt_corr), 32'd33);
    check("sweep.cnt_corr4_sat", 32'(cnt_corr4), 32'd15);

    code = 32'h0000_0000; code[20] = 1'b1;
    xfer(code, 16'h0000, 2'b01, 1'b0, "chk_p0");
    check("p0.cnt_corr", 32'(cnt_corr), 32'd34);

    code = 32'hFFFF_0000; code[0] = 1'b0; code[1] = 1'b0;
    xfer(code, 16'h77FF, 2'b10, 1'b0, "double");
    check("double.cnt_uncorr", 32'(cnt_uncorr), 32'd1);
    check("double.cnt_corr", 32'(cnt_corr), 32'd34);

    code = 32'hFFFF_0000; code[9] = ~code[9];
    xfer(code, 16'hFFFF, 2'b01, 1'b1, "clr_vs_inc");
    check("clr.cnt_corr", 32'(cnt_corr), 32'd0);
    check("clr.cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    check("clr.cnt_corr4", 32'(cnt_corr4), 32'd0);

    // Backpressure stream
    sdata = '{16'h0001, 16'h1234, 16'hFFFF, 16'hA5C3, 16'h8000, 16'h0F0F, 16'h5555, 16'hC3A5};
    ordy  = '{1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    for (int w = 0; w < 8; w++) begin
      scode[w] = encode(sdata[w]);
      sexp[w]  = sdata[w];
      sst[w]   = 2'b00;
    end
    scode[1][7] = ~scode[1][7];  sst[1] = 2'b01;
    scode[4][22] = ~scode[4][22]; sst[4] = 2'b01;
    scode[6][0] = ~scode[6][0]; scode[6][1] = ~scode[6][1]; sst[6] = 2'b10;
    sexp[6][0] = ~sexp[6][0]; sexp[6][4] = ~sexp[6][4];

    tx = 0; rx = 0; held = 0; saw_full = 0; hd = '0; hs = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      @(negedge clk);
      bus.out_ready = (c < 16) ? ordy[c] : 1'b1;
      bus.in_valid  = (tx < 8);
      bus.in_code   = (tx < 8) ? scode[tx] : '0;
      #1;
      if (held) begin
        check($sformatf("bp.hold_valid_c%0d", c), 32'(bus.out_valid), 32'd1);
        check($sformatf("bp.hold_data_c%0d", c), 32'(bus.out_data), 32'(hd));
        check($sformatf("bp.hold_status_c%0d", c), 32'(bus.out_status), 32'(hs));
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp.data_%0d", rx), 32'(bus.out_data), 32'(sexp[rx]));
        check($sformatf("bp.status_%0d", rx), 32'(bus.out_status), 32'(sst[rx]));
        rx++;
        held = 0;
      end else if (bus.out_valid) begin
        held = 1; hd = bus.out_data; hs = bus.out_status;
      end else begin
        held = 0;
      end
      if (!bus.in_ready) saw_full = 1;
      if (bus.in_valid && bus.in_ready) tx++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("bp.rx_count", 32'(rx), 32'd8);
    check("bp.tx_count", 32'(tx), 32'd8);
    check("bp.saw_full", 32'(saw_full), 32'd1);
    @(negedge clk);
    check("bp.no_dup", 32'(bus.out_valid), 32'd0);
    check("bp.cnt_corr", 32'(cnt_corr), 32'd2);
    check("bp.cnt_uncorr", 32'(cnt_uncorr), 32'd1);

    // Reset with both stages occupied and output stalled
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_code = encode(16'h1111);
    @(negedge clk);
    bus.in_code = encode(16'h2222);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid.out_valid_pre", 32'(bus.out_valid), 32'd1);
    check("mid.in_ready_full", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid.out_valid_rst", 32'(bus.out_valid), 32'd0);
    check("mid.in_ready_rst", 32'(bus.in_ready), 32'd1);
    check("mid.cnt_corr_rst", 32'(cnt_corr), 32'd0);
    check("mid.cnt_uncorr_rst", 32'(cnt_uncorr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid.no_replay_%0d", c), 32'(bus.out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
